tb_finish_monitor: RTL
======================

# tb_finish_monitor

Parametrised end-of-test monitor for SOPHON simulation benches. It generalises the single-hart ecall/gp finish check to `NUM_HART` harts. Each hart has a configurable drain window, a global timeout and a progress (stall) watchdog. All results are registered and sticky, so the bench only samples `done_o` and calls `$finish`. It sits in `tb` beside `SOPHON_TOP`, fed by hierarchical taps of `is_ecall`, `regfile[3]` and the retire strobe.

## Interface
- `NUM_HART`, default 1: number of monitored harts, range 1..8.
- `TO_BIT`, default 18: global timeout counter width; timeout fires at 2^TO_BIT-1 cycles.
- `STALL_BIT`, default 12: stall counter width; stall fires after 2^STALL_BIT-1 cycles with no retire on any hart.
- `DRAIN_CYC`, default 255: cycles from ecall to gp sampling, range 1..2^16-1.
- `PASS_CODE`, default 32'd1: gp value that means pass.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: synchronous, active-low reset.
- `en_i` in 1: monitor enable; while low, all counters hold.
- `ecall_i` in NUM_HART: per-hart ecall pulse or level.
- `retire_i` in NUM_HART: per-hart instruction-retire strobe.
- `gp_i` in NUM_HART*32: per-hart gp (x3); hart h occupies bits [32h+31:32h].
- `done_o` out 1: test finished by any cause. Sticky.
- `pass_o` out 1: all harts finished and every latched gp equals PASS_CODE.
- `fail_o` out 1: all harts finished and at least one latched gp differs from PASS_CODE.
- `timeout_o` out 1: global timeout expired before all harts finished.
- `stall_o` out 1: stall watchdog expired before all harts finished.
- `fail_hart_o` out max(1,$clog2(NUM_HART)): lowest-index hart whose gp failed. Zero unless fail_o.
- `fail_code_o` out 32: latched gp of fail_hart_o. Zero unless fail_o.
- `cycle_cnt_o` out TO_BIT: enabled cycles elapsed; freezes when done.

## Operation
- **Per-hart FSM** (`RUN`, `DRAIN`, `FIN`):
  - `RUN` moves to `DRAIN` on an edge with en_i && ecall_i[h]; the drain counter is cleared to 0.
  - `DRAIN` increments the counter each enabled cycle. On the edge where the counter equals DRAIN_CYC-1, the FSM moves to `FIN` and gp_i[h] is latched into `gp_q[h]`.
  - `FIN` is absorbing. Further ecalls in `DRAIN` or `FIN` are ignored.
- **Global timeout counter:** increments on each enabled cycle while not done and saturates at all-ones.
- **Stall counter:** cleared on any enabled cycle with |retire_i, otherwise incremented. Saturates at all-ones.
- **Result register:** loaded once, then frozen until reset. Priority on the same edge is:
  1. all harts in `FIN` gives pass/fail;
  2. else timeout counter all-ones gives timeout;
  3. else stall counter all-ones gives stall.
- Exactly one of pass_o, fail_o, timeout_o, stall_o is high when done_o=1.
- **fail_hart_o:** priority-encoded from the lowest h with gp_q[h] != PASS_CODE.
- **Reset values:** every output 0 and every FSM in `RUN`. A reset mid-drain or after done discards all state.

## Timing
- With ecall seen at edge E, gp is latched at edge E+DRAIN_CYC.
- done_o and the result flags rise at edge E+DRAIN_CYC+1, where E+DRAIN_CYC is the edge the last hart enters `FIN`.
- Timeout: done_o/timeout_o rise one edge after cycle_cnt reaches 2^TO_BIT-1.
- Stall: done_o/stall_o rise one edge after the stall counter reaches 2^STALL_BIT-1.
- If the last hart enters `FIN` on the same edge the timeout counter saturates, pass/fail wins.
- en_i low freezes every FSM, counter and latch. Ecalls while en_i is low are lost.
- Outputs are purely registered; there is no combinational path from inputs.

## Structure
- `tb_finish_pkg` holds:
  - the per-hart state enum `hart_st_e` (RUN/DRAIN/FIN);
  - the result enum `result_e` (NONE/PASS/FAIL/TIMEOUT/STALL);
  - the default constants for PASS_CODE and DRAIN_CYC.
- Sub-module `tb_finish_hart` contains one hart's FSM, drain counter and gp latch, and is instantiated NUM_HART times in a generate loop.
- The top level holds the timeout counter, stall counter, result register and fail encoder.

## Test plan
- **Single-hart pass:** NUM_HART=1, DRAIN_CYC=4, ecall at cycle 10, gp=1 → gp latched at cycle 14; done_o=pass_o=1 at cycle 15; cycle_cnt_o frozen.
- **Multi-hart fail:** NUM_HART=4; harts 0 and 2 end with gp=1, hart 1 with gp=0x5, hart 3 with gp=0x9 → fail_o=1, fail_hart_o=1, fail_code_o=0x5, and done_o only after the last hart's drain.
- **Timeout:** TO_BIT=6, retire toggling and no ecall → done_o=timeout_o=1 at cycle 64 (counter 63 plus one edge); ecall afterwards has no effect.
- **Stall:** STALL_BIT=4, retire_i held 0 after cycle 5 → stall_o=1 at cycle 21. A retire pulse at cycle 12 delays stall_o to cycle 28.
- **Race:** last hart enters `FIN` on the same edge the timeout counter saturates → pass_o=1, timeout_o=0.
- **Reset and enable:** reset asserted mid-`DRAIN` → all outputs 0 on the next edge and the FSM back to `RUN`. en_i low for 10 cycles during `DRAIN` → gp latch delayed by exactly 10 cycles.

Source files
------------

// File: rtl/tb_finish_pkg.sv
// Shared types and defaults for the end-of-test finish monitor.
// Per-hart drain FSM states, sticky result encoding, default pass code and drain length.
package tb_finish_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FIN
    } hart_st_e;

    typedef enum logic [2:0] {
        NONE,
        PASS,
        FAIL,
        TIMEOUT,
        STALL
    } result_e;

    localparam logic [31:0] PASS_CODE_DEF = 32'd1;
    localparam int          DRAIN_CYC_DEF = 255;
    localparam int          DRAIN_W       = 16;

endpackage

// File: rtl/tb_finish_hart.sv
// One hart's finish tracker: waits DRAIN_CYC enabled cycles after ecall, then latches gp.
// Latency: gp latched DRAIN_CYC enabled edges after the ecall edge; fin_o registered.
// No backpressure: en_i low freezes state, and ecalls seen while frozen are dropped.
module tb_finish_hart
    import tb_finish_pkg::*;
#(
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        ecall_i,
    input  logic [31:0] gp_i,
    output logic        fin_o,
    output logic [31:0] gp_q_o
);

    localparam logic [DRAIN_W-1:0] LAST_CNT = DRAIN_W'(DRAIN_CYC - 1);

    hart_st_e           state_q, state_d;
    logic [DRAIN_W-1:0] cnt_q, cnt_d;
    logic [31:0]        gp_q, gp_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gp_d    = gp_q;
        if (en_i) begin
            case (state_q)
                RUN: begin
                    if (ecall_i) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
                DRAIN: begin
                    // gp is sampled on the same edge the drain window closes
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIN;
                        gp_d    = gp_i;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= '0;
            gp_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gp_q    <= gp_d;
        end
    end

    assign fin_o  = (state_q == FIN);
    assign gp_q_o = gp_q;

endmodule

// File: rtl/tb_finish_monitor.sv
// Multi-hart end-of-test monitor: drain/gp check per hart, global timeout, retire-stall watchdog.
// Latency: result flags rise one edge after the deciding condition; all outputs registered.
// No backpressure: result is sticky until reset; en_i low freezes all counters and FSMs.
module tb_finish_monitor
    import tb_finish_pkg::*;
#(
    parameter int          NUM_HART  = 1,
    parameter int          TO_BIT    = 18,
    parameter int          STALL_BIT = 12,
    parameter int          DRAIN_CYC = DRAIN_CYC_DEF,
    parameter logic [31:0] PASS_CODE = PASS_CODE_DEF,
    localparam int         HW        = (NUM_HART > 1) ? $clog2(NUM_HART) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [NUM_HART-1:0]      ecall_i,
    input  logic [NUM_HART-1:0]      retire_i,
    input  logic [NUM_HART*32-1:0]   gp_i,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     fail_o,
    output logic                     timeout_o,
    output logic                     stall_o,
    output logic [HW-1:0]            fail_hart_o,
    output logic [31:0]              fail_code_o,
    output logic [TO_BIT-1:0]        cycle_cnt_o
);

    logic [NUM_HART-1:0] fin;
    logic [NUM_HART-1:0] bad;
    logic [31:0]         gp_q [NUM_HART];

    for (genvar h = 0; h < NUM_HART; h++) begin : g_hart
        tb_finish_hart #(
            .DRAIN_CYC (DRAIN_CYC)
        ) u_hart (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (en_i),
            .ecall_i (ecall_i[h]),
            .gp_i    (gp_i[32*h +: 32]),
            .fin_o   (fin[h]),
            .gp_q_o  (gp_q[h])
        );
        assign bad[h] = (gp_q[h] != PASS_CODE);
    end

    logic [HW-1:0] enc_hart;
    logic [31:0]   enc_code;

    // Walk downwards so the lowest failing hart is the last one written
    always_comb begin
        enc_hart = '0;
        enc_code = '0;
        for (int h = NUM_HART - 1; h >= 0; h--) begin
            if (bad[h]) begin
                enc_hart = HW'(h);
                enc_code = gp_q[h];
            end
        end
    end

    logic [TO_BIT-1:0]    to_cnt_q;
    logic [STALL_BIT-1:0] st_cnt_q;
    result_e              result_q;
    logic [HW-1:0]        fail_hart_q;
    logic [31:0]          fail_code_q;
    logic                 done;
    logic                 all_fin;
    logic                 to_sat;
    logic                 st_sat;

    assign done    = (result_q != NONE);
    assign all_fin = &fin;
    assign to_sat  = &to_cnt_q;
    assign st_sat  = &st_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            to_cnt_q    <= '0;
            st_cnt_q    <= '0;
            result_q    <= NONE;
            fail_hart_q <= '0;
            fail_code_q <= '0;
        end else begin
            if (en_i && !done && !to_sat) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (en_i) begin
                if (|retire_i) begin
                    st_cnt_q <= '0;
                end else if (!st_sat) begin
                    st_cnt_q <= st_cnt_q + 1'b1;
                end
            end
            // Completion outranks timeout, which outranks stall, on the same edge
            if (!done) begin
                if (all_fin) begin
                    if (|bad) begin
                        result_q    <= FAIL;
                        fail_hart_q <= enc_hart;
                        fail_code_q <= enc_code;
                    end else begin
                        result_q <= PASS;
                    end
                end else if (to_sat) begin
                    result_q <= TIMEOUT;
                end else if (st_sat) begin
                    result_q <= STALL;
                end
            end
        end
    end

    assign done_o      = done;
    assign pass_o      = (result_q == PASS);
    assign fail_o      = (result_q == FAIL);
    assign timeout_o   = (result_q == TIMEOUT);
    assign stall_o     = (result_q == STALL);
    assign fail_hart_o = fail_hart_q;
    assign fail_code_o = fail_code_q;
    assign cycle_cnt_o = to_cnt_q;

endmodule
